// File: rtl/busperm_pipe.sv
// busperm_pipe: pipelined butterfly lane permutator with shadow/active control snapshotted per beat.
// Define BUSPERM_CNT_EN to enable the 16-bit delivered-beat counter on beat_cnt.
module busperm_pipe #(
  parameter int NLANES = 8,
  parameter int LANE_W = 4,
  localparam int LOG2N = $clog2(NLANES),
  localparam int CTRL_W = LOG2N * NLANES / 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NLANES*LANE_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NLANES*LANE_W-1:0] out_data,
  input  logic                     cfg_we,
  input  logic [CTRL_W-1:0]        cfg_data,
  input  logic                     cfg_commit,
  output logic [15:0]              beat_cnt
);
  localparam int DW = NLANES * LANE_W;
  localparam int H = NLANES / 2;

  function automatic logic [DW-1:0] butterfly(input logic [DW-1:0] x, input int s, input logic [H-1:0] c);
    logic [DW-1:0] y;
    int d, a;
    y = x;
    d = NLANES >> (s + 1);
    for (int k = 0; k < H; k++) begin
      a = (k / d) * 2 * d + k % d;
      if (c[k]) begin
        y[a*LANE_W +: LANE_W] = x[(a+d)*LANE_W +: LANE_W];
        y[(a+d)*LANE_W +: LANE_W] = x[a*LANE_W +: LANE_W];
      end
    end
    return y;
  endfunction

  logic              advance;
  logic [CTRL_W-1:0] shadow, active;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk)
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (cfg_we) shadow <= cfg_data;
      if (cfg_commit) active <= shadow;
    end

  // Each stage carries forward only the control slices still needed downstream.
  for (genvar s = 0; s < LOG2N; s++) begin : g_st
    logic [DW-1:0]            q;
    logic                     v;
    logic [DW-1:0]            din;
    logic                     vin;
    logic [(LOG2N-s)*H-1:0]   cin;
    if (s == 0) begin : g_src
      assign din = in_data;
      assign vin = in_valid;
      assign cin = active;
    end else begin : g_src
      assign din = g_st[s-1].q;
      assign vin = g_st[s-1].v;
      assign cin = g_st[s-1].g_c.c;
    end
    always_ff @(posedge clk)
      if (!rst_n) begin
        q <= '0;
        v <= 1'b0;
      end else if (advance) begin
        q <= butterfly(din, s, cin[H-1:0]);
        v <= vin;
      end
    if (s < LOG2N - 1) begin : g_c
      logic [(LOG2N-1-s)*H-1:0] c;
      always_ff @(posedge clk)
        if (!rst_n) c <= '0;
        else if (advance) c <= cin[(LOG2N-s)*H-1:H];
    end
  end

  assign out_valid = g_st[LOG2N-1].v;
  assign out_data  = g_st[LOG2N-1].q;

`ifdef BUSPERM_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (out_valid && out_ready) cnt <= cnt + 16'd1;
  assign beat_cnt = cnt;
`else
  assign beat_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_busperm_pipe.sv
// tb_busperm_pipe: randomized scenarios for busperm_pipe checked against a lane-destination model.
module tb_busperm_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, cfg_we, cfg_commit;
  logic [31:0] in_data, out_data;
  logic [11:0] cfg_data;
  logic [15:0] beat_cnt;

  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$], got_q[$];
  logic [11:0] sh_m = '0, act_m = '0;
  logic        obs_in_ready, obs_out_valid;
  logic [31:0] obs_out_data;

  busperm_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .cfg_we(cfg_we),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Follow each source lane to its destination: a set switch flips the distance bit of its position.
  function automatic logic [31:0] perm(input logic [31:0] x, input logic [11:0] c);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      int p;
      p = i;
      for (int s = 0; s < 3; s++) begin
        int d, lo, k;
        d = 8 >> (s + 1);
        lo = p & ~d;
        k = (lo / (2 * d)) * d + lo % d;
        if (c[s*4+k]) p = p ^ d;
      end
      y[p*4 +: 4] = x[i*4 +: 4];
    end
    return y;
  endfunction

  task automatic step();
    bit acc, del;
    #1;
    obs_in_ready = in_ready;
    obs_out_valid = out_valid;
    obs_out_data = out_data;
    acc = in_valid && in_ready;
    del = out_valid && out_ready;
    @(posedge clk);
    if (!rst_n) begin
      while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
      sh_m = '0;
      act_m = '0;
    end else begin
      if (acc) exp_q.push_back(perm(in_data, act_m));
      if (del) got_q.push_back(obs_out_data);
      if (cfg_commit) act_m = sh_m;
      if (cfg_we) sh_m = cfg_data;
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 40 && got_q.size() < exp_q.size(); i++) step();
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_tests++; if (beat_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_latency();
    int lat;
    idle();
    in_valid = 1'b1;
    in_data = 32'h76543210;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin step(); lat++; end
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL latency got=%0d exp=3", lat); end
    n_tests++; if (out_data !== 32'h76543210) begin n_fail++; $display("FAIL identity got=%h exp=76543210", out_data); end
    drain();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_cfg();
    logic [11:0] cfgs[2];
    logic [31:0] fixed[2];
    cfgs[0] = 12'h001; fixed[0] = 32'h76503214;
    cfgs[1] = 12'hFFF; fixed[1] = 32'h01234567;
    for (int r = 0; r < 8; r++) begin
      idle();
      cfg_we = 1'b1;
      cfg_data = r < 2 ? cfgs[r] : 12'($urandom);
      step();
      cfg_we = 1'b0;
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
      in_valid = 1'b1;
      for (int b = 0; b < 3; b++) begin
        in_data = (r < 2 && b == 0) ? 32'h76543210 : $urandom;
        step();
      end
      drain();
      n_tests++; if (got_q.size() != 3) begin n_fail++; $display("FAIL cfg_count round=%0d got=%0d exp=3", r, got_q.size()); end
      if (r < 2 && got_q.size() > 0) begin
        n_tests++; if (got_q[0] !== fixed[r]) begin n_fail++; $display("FAIL cfg_fixed round=%0d got=%h exp=%h", r, got_q[0], fixed[r]); end
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL cfg_beat round=%0d idx=%0d got=%h exp=%h", r, i, got_q[i], exp_q[i]); end
      end
      exp_q.delete();
      got_q.delete();
    end
  endtask

  task automatic test_stall();
    int sent;
    bit prev_stall;
    logic [31:0] prev_data;
    idle();
    sent = 0;
    prev_stall = 0;
    prev_data = '0;
    for (int cyc = 0; cyc < 80 && (sent < 10 || got_q.size() < exp_q.size()); cyc++) begin
      in_valid = sent < 10;
      in_data = $urandom;
      out_ready = !(cyc >= 6 && cyc < 11);
      step();
      if (in_valid && obs_in_ready) sent++;
      n_tests++; if (obs_in_ready !== (!obs_out_valid || out_ready)) begin n_fail++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=%b", cyc, obs_in_ready, !obs_out_valid || out_ready); end
      if (prev_stall) begin
        n_tests++; if (obs_out_data !== prev_data) begin n_fail++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, obs_out_data, prev_data); end
      end
      prev_stall = obs_out_valid && !out_ready;
      prev_data = obs_out_data;
    end
    drain();
    n_tests++; if (got_q.size() != 10 || exp_q.size() != 10) begin n_fail++; $display("FAIL stall_count got=%0d exp=10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_beat idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_inflight_commit();
    logic [31:0] fixed[4];
    fixed[0] = 32'h76543210; fixed[1] = 32'h76543210; fixed[2] = 32'h01234567; fixed[3] = 32'h01234567;
    idle();
    cfg_we = 1'b1; cfg_data = 12'h000; step();
    cfg_we = 1'b0; cfg_commit = 1'b1; step();
    cfg_commit = 1'b0; cfg_we = 1'b1; cfg_data = 12'hFFF; step();
    cfg_we = 1'b0;
    in_data = 32'h76543210;
    in_valid = 1'b1; step(); step();
    in_valid = 1'b0; cfg_commit = 1'b1; step();
    cfg_commit = 1'b0; in_valid = 1'b1; step();
    in_valid = 1'b0; cfg_we = 1'b1; cfg_data = 12'h0A5; step();
    cfg_data = 12'h123; cfg_commit = 1'b1; in_valid = 1'b1; step();
    cfg_we = 1'b0; cfg_commit = 1'b0; in_data = $urandom; step();
    in_valid = 1'b0; cfg_commit = 1'b1; step();
    cfg_commit = 1'b0; in_valid = 1'b1; in_data = $urandom; step();
    drain();
    n_tests++; if (got_q.size() != 6) begin n_fail++; $display("FAIL commit_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_tests++; if (got_q[i] !== fixed[i]) begin n_fail++; $display("FAIL commit_fixed idx=%0d got=%h exp=%h", i, got_q[i], fixed[i]); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL commit_beat idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_midstream();
    bit stale;
    idle();
    cfg_we = 1'b1; cfg_data = 12'h5A5; step();
    cfg_we = 1'b0; cfg_commit = 1'b1; step();
    cfg_commit = 1'b0; in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin in_data = $urandom; step(); end
    do_reset();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (beat_cnt !== 16'h0) begin n_fail++; $display("FAIL midrst_beat_cnt got=%0d exp=0", beat_cnt); end
    idle();
    stale = 0;
    for (int i = 0; i < 6; i++) begin step(); if (obs_out_valid) stale = 1; end
    n_tests++; if (stale !== 1'b0) begin n_fail++; $display("FAIL midrst_stale got=%b exp=0", stale); end
    in_valid = 1'b1; in_data = 32'h76543210; step();
    drain();
    n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL midrst_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_tests++; if (got_q[0] !== 32'h76543210) begin n_fail++; $display("FAIL midrst_identity got=%h exp=76543210", got_q[0]); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_count();
    int sent;
    logic [15:0] exp_cnt;
    do_reset();
    idle();
    cfg_we = 1'b1; cfg_data = 12'($urandom); step();
    cfg_we = 1'b0; cfg_commit = 1'b1; step();
    cfg_commit = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 300 && sent < 20; cyc++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_data = $urandom;
      out_ready = $urandom_range(0, 2) != 0;
      step();
      if (in_valid && obs_in_ready) sent++;
    end
    drain();
`ifdef BUSPERM_CNT_EN
    exp_cnt = 16'd20;
`else
    exp_cnt = 16'd0;
`endif
    n_tests++; if (got_q.size() != 20) begin n_fail++; $display("FAIL count_delivered got=%0d exp=20", got_q.size()); end
    n_tests++; if (beat_cnt !== exp_cnt) begin n_fail++; $display("FAIL beat_cnt got=%0d exp=%0d", beat_cnt, exp_cnt); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL count_beat idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = '0;
    cfg_data = '0;
    idle();
    test_reset();
    test_latency();
    test_cfg();
    test_stall();
    test_inflight_commit();
    test_reset_midstream();
    test_count();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
